// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared constants for the seven-segment scanner.
// Segment patterns are active low, ordered {g,f,e,d,c,b,a}.
package seven_seg_pkg;
    localparam logic [3:0] ANODE_OFF = 4'b1111;
    localparam logic [6:0] SEG_OFF   = 7'h7F;
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = SEG_LUT[nibble];
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: scans a 16-bit value as four hex digits on a common-anode display.
// Define SEVEN_SEG_LZB_EN to blank leading zero digits (digit 0 is always lit).
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] data_in,
    output logic [3:0]  anode,
    output logic [6:0]  segments,
    output logic        dp,
    output logic        frame_tick
);
    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [3:0]    anode_q, anode_d;
    logic [6:0]    segments_q, segments_d;
    logic          frame_tick_q, frame_tick_d;
    logic          wrap, blank;
    logic [3:0]    nib;
    logic [6:0]    seg_next;

    hex_to_seg u_hex_to_seg (
        .nibble (nib),
        .seg    (seg_next)
    );

    // Outputs are derived from next-state idx/shadow so they change on the same edge.
    always_comb begin
        wrap         = cnt_q == CW'(REFRESH_DIV - 1);
        cnt_d        = wrap ? '0 : cnt_q + 1'b1;
        idx_d        = wrap ? idx_q + 2'd1 : idx_q;
        frame_tick_d = wrap && idx_q == 2'd3;
        shadow_d     = frame_tick_d ? data_in : shadow_q;
        nib          = shadow_d[{idx_d, 2'b00} +: 4];
`ifdef SEVEN_SEG_LZB_EN
        blank        = idx_d != 2'd0 && (shadow_d >> {idx_d, 2'b00}) == 16'h0;
`else
        blank        = 1'b0;
`endif
        anode_d      = blank ? ANODE_OFF : ~(4'b0001 << idx_d);
        segments_d   = seg_next;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            shadow_q     <= 16'h0;
            anode_q      <= ANODE_OFF;
            segments_q   <= SEG_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            anode_q      <= anode_d;
            segments_q   <= segments_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign anode      = anode_q;
    assign segments   = segments_q;
    assign dp         = 1'b1;
    assign frame_tick = frame_tick_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed scoreboard bench for seven_seg_scanner with REFRESH_DIV=4.
module tb_seven_seg_scanner;
    typedef struct packed {
        logic [3:0] an;
        logic [6:0] sg;
        logic       tk;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] data_in = 16'h1234;
    logic [3:0]  anode;
    logic [6:0]  segments;
    logic        dp;
    logic        frame_tick;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    logic [6:0] lut [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    seven_seg_scanner #(.REFRESH_DIV(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .anode      (anode),
        .segments   (segments),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_anode"}, {3'b0, anode}, 7'h0F);
        chk({tag, "_segments"}, segments, 7'h7F);
        chk({tag, "_dp"}, {6'b0, dp}, 7'h01);
        chk({tag, "_tick"}, {6'b0, frame_tick}, 7'h00);
    endtask

    // Expected output for frame positions first..last (4 cycles per digit) showing value v.
    task automatic push_range(input logic [15:0] v, input int first, input int last, input logic tick0);
        exp_t        e;
        int          k;
        logic [15:0] sh;
        for (int i = first; i <= last; i++) begin
            k    = i / 4;
            sh   = v >> (4 * k);
            e.sg = lut[sh[3:0]];
            e.an = ~(4'b0001 << k);
`ifdef SEVEN_SEG_LZB_EN
            if (k > 0 && sh == 16'h0) e.an = 4'b1111;
`endif
            e.tk = tick0 && i == 0;
            sb.push_back(e);
        end
    endtask

    task automatic run(input int n);
        exp_t e;
        repeat (n) begin
            @(posedge clock);
            #1;
            e = sb.pop_front();
            chk("anode", {3'b0, anode}, {3'b0, e.an});
            chk("segments", segments, e.sg);
            chk("frame_tick", {6'b0, frame_tick}, {6'b0, e.tk});
        end
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk_reset_outputs("in_reset");
        reset_n = 1'b1;
        push_range(16'h0000, 1, 15, 1'b0);
        run(15);
        push_range(16'h1234, 0, 15, 1'b1);
        run(16);
        push_range(16'h1234, 0, 9, 1'b1);
        run(10);
        data_in = 16'hABCD;
        push_range(16'h1234, 10, 15, 1'b0);
        run(6);
        push_range(16'hABCD, 0, 15, 1'b1);
        run(16);
        data_in = 16'h0F00;
        push_range(16'h0F00, 0, 15, 1'b1);
        run(16);
        data_in = 16'h0007;
        push_range(16'h0007, 0, 15, 1'b1);
        run(16);
        data_in = 16'h0000;
        push_range(16'h0000, 0, 15, 1'b1);
        run(16);
        data_in = 16'h1234;
        push_range(16'h1234, 0, 9, 1'b1);
        run(10);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(posedge clock);
        #1;
        chk_reset_outputs("held_reset");
        reset_n = 1'b1;
        push_range(16'h0000, 1, 15, 1'b0);
        run(15);
        push_range(16'h1234, 0, 3, 1'b1);
        run(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
